// File: rtl/dbuf_load_ctrl.sv
// -----------------------------------------------------------------------------
// dbuf_load_ctrl
//
// Tile sequencer for the DDR-to-data-buffer loader. It accepts one layer
// command and then walks its tiles. For each tile it:
//   1. configures the loader,
//   2. issues burst read requests on DDR read channel 1, and on channel 2 as
//      well in CONV mode,
//   3. waits for the loader to report that the tile is complete.
// After the last tile it pulses done and returns to idle. This block owns the
// loader configuration port exclusively.
//
// Optional feature:
//   DBUF_LOAD_WDOG_EN - when defined, a 20-bit watchdog bounds the wait for
//                       tile completion. On expiry it sets the sticky err
//                       flag and returns to idle without pulsing done. When
//                       undefined, err is tied low and the wait is unbounded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_*             layer command (valid/ready) with loader fields, tile
//                     count, per-stream base addresses and tile stride
//   ld_conf_*         loader configuration (valid/ready); ld_conf_ready also
//                     signals tile completion while waiting
//   rd1_req_*         DDR read channel 1 burst request (valid/ready/addr/len)
//   rd2_req_*         DDR read channel 2 burst request (CONV mode only)
//   busy              a layer is in progress
//   done              one-cycle pulse when the layer finishes
//   err               sticky watchdog error
// -----------------------------------------------------------------------------
module dbuf_load_ctrl #(
  parameter int PE_NUM     = 32,
  parameter int DDR_ADDR_W = 32,
  parameter int TILE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_mode,
  input  logic [3:0]            cmd_ch_num,
  input  logic [3:0]            cmd_row_num,
  input  logic [3:0]            cmd_pix_num,
  input  logic                  cmd_depool,
  input  logic [PE_NUM-1:0]     cmd_mask,
  input  logic [TILE_W-1:0]     cmd_tile_num,
  input  logic [DDR_ADDR_W-1:0] cmd_src1_addr,
  input  logic [DDR_ADDR_W-1:0] cmd_src2_addr,
  input  logic [DDR_ADDR_W-1:0] cmd_tile_stride,
  output logic                  ld_conf_valid,
  input  logic                  ld_conf_ready,
  output logic [3:0]            ld_conf_mode,
  output logic [3:0]            ld_conf_ch_num,
  output logic [3:0]            ld_conf_row_num,
  output logic [3:0]            ld_conf_pix_num,
  output logic [PE_NUM-1:0]     ld_conf_mask,
  output logic                  ld_conf_depool,
  output logic                  rd1_req_valid,
  input  logic                  rd1_req_ready,
  output logic [DDR_ADDR_W-1:0] rd1_req_addr,
  output logic [15:0]           rd1_req_len,
  output logic                  rd2_req_valid,
  input  logic                  rd2_req_ready,
  output logic [DDR_ADDR_W-1:0] rd2_req_addr,
  output logic [15:0]           rd2_req_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONF = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                  state_r;
  logic [TILE_W-1:0]       tile_cnt_r;
  logic [TILE_W-1:0]       tile_num_r;
  logic [DDR_ADDR_W-1:0]   stride_r;

  logic                    is_conv_s;
  logic [11:0]             prod_s;
  logic [15:0]             len_s;
  logic                    rd1_left_s;
  logic                    rd2_left_s;
  logic                    last_tile_s;

`ifdef DBUF_LOAD_WDOG_EN
  logic [19:0]             wdog_r;
`else
  assign err = 1'b0;
`endif

  // Burst length, outstanding-request flags and last-tile detect.
  // The latched loader fields live in the ld_conf_* output registers.
  always_comb begin
    is_conv_s = (ld_conf_mode[2:1] == 2'b01);
    // The product is kept to 12 bits on purpose: 16*16*16 wraps to 0.
    prod_s = ({8'd0, ld_conf_ch_num}  + 12'd1) *
             ({8'd0, ld_conf_pix_num} + 12'd1) *
             ({8'd0, ld_conf_row_num} + 12'd1);
    if (is_conv_s) begin
      len_s = {4'd0, prod_s};
    end else begin
      len_s = {12'd0, ld_conf_ch_num} + 16'd1;
    end
    // A request is still pending if its valid is up and it is not accepted
    // on this edge.
    rd1_left_s  = rd1_req_valid & ~rd1_req_ready;
    rd2_left_s  = rd2_req_valid & ~rd2_req_ready;
    last_tile_s = (tile_cnt_r == tile_num_r);
  end

  // Sequencer FSM: latched layer fields and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_IDLE;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      ld_conf_valid   <= 1'b0;
      rd1_req_valid   <= 1'b0;
      rd2_req_valid   <= 1'b0;
      ld_conf_mode    <= 4'd0;
      ld_conf_ch_num  <= 4'd0;
      ld_conf_row_num <= 4'd0;
      ld_conf_pix_num <= 4'd0;
      ld_conf_mask    <= {PE_NUM{1'b0}};
      ld_conf_depool  <= 1'b0;
      rd1_req_addr    <= {DDR_ADDR_W{1'b0}};
      rd2_req_addr    <= {DDR_ADDR_W{1'b0}};
      rd1_req_len     <= 16'd0;
      rd2_req_len     <= 16'd0;
      tile_cnt_r      <= {TILE_W{1'b0}};
      tile_num_r      <= {TILE_W{1'b0}};
      stride_r        <= {DDR_ADDR_W{1'b0}};
`ifdef DBUF_LOAD_WDOG_EN
      err             <= 1'b0;
      wdog_r          <= 20'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ld_conf_mode    <= cmd_mode;
            ld_conf_ch_num  <= cmd_ch_num;
            ld_conf_row_num <= cmd_row_num;
            ld_conf_pix_num <= cmd_pix_num;
            ld_conf_mask    <= cmd_mask;
            ld_conf_depool  <= cmd_depool;
            rd1_req_addr    <= cmd_src1_addr;
            rd2_req_addr    <= cmd_src2_addr;
            stride_r        <= cmd_tile_stride;
            tile_num_r      <= cmd_tile_num;
            tile_cnt_r      <= {TILE_W{1'b0}};
            cmd_ready       <= 1'b0;
            busy            <= 1'b1;
            ld_conf_valid   <= 1'b1;
            state_r         <= S_CONF;
          end
        end
        S_CONF: begin
          if (ld_conf_ready) begin
            ld_conf_valid <= 1'b0;
            rd1_req_valid <= 1'b1;
            rd2_req_valid <= is_conv_s;
            rd1_req_len   <= len_s;
            rd2_req_len   <= len_s;
            state_r       <= S_REQ;
          end
        end
        S_REQ: begin
          rd1_req_valid <= rd1_left_s;
          rd2_req_valid <= rd2_left_s;
          if (!rd1_left_s && !rd2_left_s) begin
            state_r <= S_WAIT;
`ifdef DBUF_LOAD_WDOG_EN
            wdog_r  <= 20'd0;
`endif
          end
        end
        S_WAIT: begin
          // ld_conf_ready here means the loader finished the tile.
          if (ld_conf_ready) begin
            if (last_tile_s) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state_r   <= S_IDLE;
            end else begin
              tile_cnt_r    <= tile_cnt_r + {{(TILE_W-1){1'b0}}, 1'b1};
              rd1_req_addr  <= rd1_req_addr + stride_r;
              rd2_req_addr  <= rd2_req_addr + stride_r;
              // Advance the PE write mask by one group of 4, wrapping around.
              ld_conf_mask  <= {ld_conf_mask[PE_NUM-5:0], ld_conf_mask[PE_NUM-1:PE_NUM-4]};
              ld_conf_valid <= 1'b1;
              state_r       <= S_CONF;
            end
          end
`ifdef DBUF_LOAD_WDOG_EN
          else if (wdog_r == 20'hFFFFF) begin
            err       <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
          end else begin
            wdog_r <= wdog_r + 20'd1;
          end
`endif
        end
        default: begin
          ld_conf_valid <= 1'b0;
          rd1_req_valid <= 1'b0;
          rd2_req_valid <= 1'b0;
          cmd_ready     <= 1'b1;
          busy          <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
